// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the signalised-junction controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED    = 2'd0,
    RED_YELLOW = 2'd1,
    GREEN      = 2'd2,
    YELLOW     = 2'd3
  } phase_t;

  localparam int DEF_NUM_WAYS     = 4;
  localparam int DEF_TICK_DIV     = 500;
  localparam int DEF_ALL_RED_T    = 400;
  localparam int DEF_RED_YELLOW_T = 400;
  localparam int DEF_GREEN_T      = 4200;
  localparam int DEF_YELLOW_T     = 1000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clk timing tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = w_wrap;

  // Count 0..TICK_DIV-1 and wrap; the tick is the last count of each period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-way junction controller: phase FSM, tick timer, demand latch, next-way
// selection and emergency pre-emption, all on a single clock.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS     = DEF_NUM_WAYS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ALL_RED_T    = DEF_ALL_RED_T,
  parameter int RED_YELLOW_T = DEF_RED_YELLOW_T,
  parameter int GREEN_T      = DEF_GREEN_T,
  parameter int YELLOW_T     = DEF_YELLOW_T,
  localparam int WAY_W       = max2(1, $clog2(NUM_WAYS))
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                skip_en,
  input  logic [NUM_WAYS-1:0] req,
  input  logic                preempt_req,
  input  logic [WAY_W-1:0]    preempt_way,
  output logic [NUM_WAYS-1:0] red,
  output logic [NUM_WAYS-1:0] yellow,
  output logic [NUM_WAYS-1:0] green,
  output logic [WAY_W-1:0]    active_way,
  output logic                phase_done,
  output logic                preempt_active
);

  localparam int MAX_T = max2(max2(ALL_RED_T, RED_YELLOW_T), max2(GREEN_T, YELLOW_T));
  localparam int TMR_W = max2(1, $clog2(MAX_T));

  phase_t              r_phase;
  logic [TMR_W-1:0]    r_timer;
  logic [WAY_W-1:0]    r_way;
  logic [NUM_WAYS-1:0] r_pending;
  logic                r_phase_done;
  logic                r_preempt_active;

  logic                w_tick;
  logic                w_at_end;
  logic                w_leave;
  logic                w_pre_other;
  logic                w_pre_self;
  phase_t              w_phase_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic [WAY_W-1:0]    w_way_nxt;
  logic                w_done_nxt;
  logic                w_hold_nxt;
  logic                w_enter_green;
  logic [NUM_WAYS-1:0] w_clr_mask;
  logic [WAY_W-1:0]    w_rr_way;
  logic [WAY_W-1:0]    w_cand;
  logic [WAY_W-1:0]    w_skip_way;
  logic                w_found;
  logic [WAY_W-1:0]    w_sel_way;

  // Advance an approach index with wrap-around at NUM_WAYS (not a power of two in general).
  function automatic logic [WAY_W-1:0] wrap_inc(input logic [WAY_W-1:0] w);
    return (w == WAY_W'(NUM_WAYS - 1)) ? '0 : w + 1'b1;
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .o_tick  (w_tick)
  );

  assign w_pre_other = preempt_req && (preempt_way != r_way);
  assign w_pre_self  = preempt_req && (preempt_way == r_way);
  assign w_leave     = w_tick && w_at_end;

  // Detect the last tick of the current phase (timer == duration-1).
  always_comb begin
    w_at_end = 1'b0;
    case (r_phase)
      ALL_RED:    w_at_end = (r_timer == TMR_W'(ALL_RED_T - 1));
      RED_YELLOW: w_at_end = (r_timer == TMR_W'(RED_YELLOW_T - 1));
      GREEN:      w_at_end = (r_timer == TMR_W'(GREEN_T - 1));
      YELLOW:     w_at_end = (r_timer == TMR_W'(YELLOW_T - 1));
      default:    w_at_end = 1'b1;
    endcase
  end

  // Choose the approach to serve next: pre-emption, then first pending after active, then round-robin.
  always_comb begin
    w_rr_way   = wrap_inc(r_way);
    w_cand     = w_rr_way;
    w_found    = 1'b0;
    w_skip_way = w_rr_way;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (!w_found && r_pending[w_cand]) begin
        w_found    = 1'b1;
        w_skip_way = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
    if (preempt_req) begin
      w_sel_way = preempt_way;
    end else if (skip_en) begin
      w_sel_way = w_skip_way;
    end else begin
      w_sel_way = w_rr_way;
    end
  end

  // Phase FSM next-state: normal timed sequencing plus pre-emption overrides.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_timer_nxt   = w_tick ? r_timer + 1'b1 : r_timer;
    w_way_nxt     = r_way;
    w_done_nxt    = 1'b0;
    w_hold_nxt    = 1'b0;
    w_enter_green = 1'b0;
    case (r_phase)
      ALL_RED: begin
        // Redirecting during clearance keeps the clearance time already served.
        if (w_pre_other) begin
          w_way_nxt = preempt_way;
        end
        if (w_leave) begin
          w_phase_nxt = RED_YELLOW;
          w_timer_nxt = '0;
        end
      end
      RED_YELLOW: begin
        if (w_pre_other) begin
          w_phase_nxt = ALL_RED;
          w_way_nxt   = preempt_way;
          w_timer_nxt = '0;
        end else if (w_leave) begin
          w_phase_nxt   = GREEN;
          w_timer_nxt   = '0;
          w_enter_green = 1'b1;
        end
      end
      GREEN: begin
        // Holding keeps the timer at zero so a full green follows the release.
        if (w_pre_self) begin
          w_timer_nxt = '0;
          w_hold_nxt  = 1'b1;
        end else if (w_pre_other || w_leave) begin
          w_phase_nxt = YELLOW;
          w_timer_nxt = '0;
        end
      end
      YELLOW: begin
        if (w_leave) begin
          w_phase_nxt = ALL_RED;
          w_timer_nxt = '0;
          w_way_nxt   = w_sel_way;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_phase_nxt = ALL_RED;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Demand served on entry to green; a coincident new request wins over the clear.
  always_comb begin
    w_clr_mask = '0;
    if (w_enter_green) begin
      w_clr_mask[r_way] = 1'b1;
    end
  end

  // State register for phase, timer, active approach, demand latch and registered flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase          <= ALL_RED;
      r_timer          <= '0;
      r_way            <= '0;
      r_pending        <= '0;
      r_phase_done     <= 1'b0;
      r_preempt_active <= 1'b0;
    end else begin
      r_phase          <= w_phase_nxt;
      r_timer          <= w_timer_nxt;
      r_way            <= w_way_nxt;
      r_pending        <= (r_pending & ~w_clr_mask) | req;
      r_phase_done     <= w_done_nxt;
      r_preempt_active <= w_hold_nxt;
    end
  end

  // Lamp decode from registered phase and active approach only.
  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      red[i]    = (r_way != WAY_W'(i)) || (r_phase == ALL_RED) || (r_phase == RED_YELLOW);
      yellow[i] = (r_way == WAY_W'(i)) && ((r_phase == RED_YELLOW) || (r_phase == YELLOW));
      green[i]  = (r_way == WAY_W'(i)) && (r_phase == GREEN);
    end
  end

  assign active_way     = r_way;
  assign phase_done     = r_phase_done;
  assign preempt_active = r_preempt_active;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a tick/phase-duration reference model
// predicts every cycle's outputs, a monitor compares, plus directed timing checks.
module tb_traffic_phase_ctrl;

  localparam int NW   = 4;
  localparam int TD   = 4;
  localparam int AR_T = 2;
  localparam int RY_T = 2;
  localparam int G_T  = 5;
  localparam int Y_T  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          skip_en = 1'b0;
  logic [NW-1:0] req = '0;
  logic          preempt_req = 1'b0;
  logic [1:0]    preempt_way = '0;
  logic [NW-1:0] red, yellow, green;
  logic [1:0]    active_way;
  logic          phase_done, preempt_active;

  traffic_phase_ctrl #(
    .NUM_WAYS     (NW),
    .TICK_DIV     (TD),
    .ALL_RED_T    (AR_T),
    .RED_YELLOW_T (RY_T),
    .GREEN_T      (G_T),
    .YELLOW_T     (Y_T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .skip_en        (skip_en),
    .req            (req),
    .preempt_req    (preempt_req),
    .preempt_way    (preempt_way),
    .red            (red),
    .yellow         (yellow),
    .green          (green),
    .active_way     (active_way),
    .phase_done     (phase_done),
    .preempt_active (preempt_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] red;
    logic [NW-1:0] yellow;
    logic [NW-1:0] green;
    logic [1:0]    way;
    logic          done;
    logic          pact;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: phase index 0=all-red 1=red+yellow 2=green 3=yellow.
  int        m_ph, m_t, m_way, m_div;
  bit        m_done, m_pact;
  bit [NW-1:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int pick_next();
    if (preempt_req) return int'(preempt_way);
    if (skip_en) begin
      for (int d = 1; d <= NW; d++) begin
        if (m_pend[(m_way + d) % NW]) return (m_way + d) % NW;
      end
    end
    return (m_way + 1) % NW;
  endfunction

  task automatic model_step();
    int dur[4];
    int tk, nph, nt, nway;
    bit last, other, hold, enter_g;
    dur = '{AR_T, RY_T, G_T, Y_T};
    if (!reset_n) begin
      m_ph = 0; m_t = 0; m_way = 0; m_div = 0; m_pend = '0; m_done = 0; m_pact = 0;
      return;
    end
    tk      = (m_div == TD - 1) ? 1 : 0;
    m_div   = (m_div + 1) % TD;
    last    = (tk == 1) && (m_t == dur[m_ph] - 1);
    other   = preempt_req && (int'(preempt_way) != m_way);
    hold    = preempt_req && (int'(preempt_way) == m_way);
    nph     = m_ph;
    nt      = m_t + tk;
    nway    = m_way;
    enter_g = 0;
    m_done  = 0;
    m_pact  = (m_ph == 2) && hold;
    case (m_ph)
      0: begin
        if (other) nway = int'(preempt_way);
        if (last) begin nph = 1; nt = 0; end
      end
      1: begin
        if (other) begin nph = 0; nway = int'(preempt_way); nt = 0; end
        else if (last) begin nph = 2; nt = 0; enter_g = 1; end
      end
      2: begin
        if (hold) nt = 0;
        else if (other || last) begin nph = 3; nt = 0; end
      end
      default: begin
        if (last) begin nph = 0; nt = 0; m_done = 1; nway = pick_next(); end
      end
    endcase
    if (enter_g) m_pend[m_way] = 1'b0;
    m_pend = m_pend | req;
    m_ph = nph; m_t = nt; m_way = nway;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.red[i]    = (i != m_way) || (m_ph < 2);
      e.yellow[i] = (i == m_way) && (m_ph == 1 || m_ph == 3);
      e.green[i]  = (i == m_way) && (m_ph == 2);
    end
    e.way  = 2'(m_way);
    e.done = m_done;
    e.pact = m_pact;
    return e;
  endfunction

  // One clock: predict the post-edge outputs, queue them, advance to the next negedge.
  task automatic cyc();
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; skip_en = 1'b0; req = '0; preempt_req = 1'b0; preempt_way = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  // Monitor: compare DUT against the queued prediction and the lamp invariants.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      mon_e = exp_q.pop_front();
      check("cycle_outputs", {red, yellow, green, active_way, phase_done, preempt_active}, mon_e);
    end
    check("one_green_or_yellow", ($countones(green | yellow) <= 1) ? 1 : 0, 1);
    check("red_and_green_excl", red & green, 0);
  end

  initial begin
    int first_g, nd, hold_left;

    // Scenario 1: plain round-robin timing.
    do_reset();
    first_g = -1; nd = 0;
    for (int k = 1; k <= 200; k++) begin
      cyc();
      if (green[0] && first_g < 0) first_g = k;
      if (k == 35) check("g0_on_at_35", green[0], 1);
      if (k == 36) check("g0_yellow_at_36", {green[0], yellow[0]}, 2'b01);
      if (phase_done) begin
        if (nd < 4) begin
          check("done_cycle", k, 48 * (nd + 1));
          check("rr_next_way", active_way, (nd + 1) % NW);
        end
        nd++;
      end
    end
    check("first_green_cycle", first_g, 16);
    check("done_count", nd, 4);

    // Scenario 2: skip with a single request for way 2.
    do_reset();
    skip_en = 1'b1;
    nd = 0;
    for (int k = 1; k <= 150; k++) begin
      if (k == 20) req = 4'b0100;
      cyc();
      req = '0;
      if (phase_done) begin
        if (nd == 0) check("skip_first_way", active_way, 2);
        if (nd == 1) check("skip_second_way", active_way, 3);
        nd++;
      end
    end
    check("skip_done_count", (nd >= 2) ? 1 : 0, 1);

    // Scenario 3: pre-empt to way 3 mid-green of way 0, held, then released.
    do_reset();
    for (int k = 1; k <= 110; k++) begin
      if (k == 25) begin preempt_req = 1'b1; preempt_way = 2'd3; end
      if (k == 81) preempt_req = 1'b0;
      cyc();
      if (k == 25) check("pre_yellow0", {yellow, green}, {4'b0001, 4'b0000});
      if (k == 35) check("pre_yellow0_held", yellow, 4'b0001);
      if (k == 36) check("pre_allred_way3", {red, active_way}, {4'hF, 2'd3});
      if (k == 51) check("pre_prepare3", yellow, 4'b1000);
      if (k == 52) check("pre_green3", green, 4'b1000);
      if (k == 70) check("pre_hold_active", {preempt_active, green}, {1'b1, 4'b1000});
      if (k == 99) check("pre_green_after_rel", green, 4'b1000);
      if (k == 100) check("pre_yellow_after_rel", {yellow, preempt_active}, {4'b1000, 1'b0});
    end

    // Scenario 4: pre-empt to way 1 while way 2 is in red+yellow.
    do_reset();
    for (int k = 1; k <= 160; k++) begin
      if (k == 107) begin preempt_req = 1'b1; preempt_way = 2'd1; end
      if (k == 131) preempt_req = 1'b0;
      cyc();
      if (k == 106) check("ry_way2", {yellow, active_way}, {4'b0100, 2'd2});
      if (k == 107) check("ry_cut_allred", {red, active_way}, {4'hF, 2'd1});
      if (k == 125) check("way1_green", green, 4'b0010);
      if (k >= 100 && green[2]) check("green2_never", green[2], 0);
    end

    // Scenario 5: asynchronous reset during yellow restarts from way 0.
    do_reset();
    for (int k = 1; k <= 40; k++) cyc();
    check("yellow0_before_rst", yellow, 4'b0001);
    reset_n = 1'b0;
    #1;
    check("async_rst_lamps", {red, yellow, green, active_way, phase_done, preempt_active},
          {4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0});
    repeat (2) cyc();
    reset_n = 1'b1;
    first_g = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (green[0] && first_g < 0) first_g = k;
    end
    check("restart_green_cycle", first_g, 16);

    // Random traffic against the reference model.
    do_reset();
    hold_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) skip_en = ~skip_en;
      req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) preempt_req = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        preempt_req = 1'b1;
        preempt_way = 2'($urandom_range(0, NW - 1));
        hold_left   = $urandom_range(1, 80);
      end
      reset_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
